// File: rtl/frame_buffer_ctrl.sv
// Frame buffer controller: captures one frame of pixels into an external BRAM,
// then reads it back in address order and streams it out with a latency-aligned valid.
module frame_buffer_ctrl #(
    parameter int unsigned RAM_DEPTH  = 512,
    parameter int unsigned RAM_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iStart,
    input  logic                  iValid,
    input  logic [RAM_WIDTH-1:0]  iData,
    output logic                  oReady,
    output logic                  oRamWe,
    output logic [ADDR_WIDTH-1:0] oRamAddr,
    output logic [RAM_WIDTH-1:0]  oRamWData,
    input  logic [RAM_WIDTH-1:0]  iRamRData,
    output logic                  oValid,
    output logic [RAM_WIDTH-1:0]  oData,
    output logic                  oBusy,
    output logic                  oFrameDone
);

    // Terminal count is compared explicitly so non-power-of-2 depths wrap correctly.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } fsmState_e;

    fsmState_e             state;
    logic [ADDR_WIDTH-1:0] wrCnt;
    logic [ADDR_WIDTH-1:0] rdCnt;
    logic [RD_LATENCY-1:0] validPipe;
    logic [RD_LATENCY-1:0] pipeNext;
    logic                  inWrite;
    logic                  inRead;
    logic                  accept;
    logic                  wrLast;
    logic                  rdLast;
    logic                  pipeDrained;

    // Phase decode, terminal counts and next value of the read-valid pipe.
    always_comb begin
        inWrite     = (state == WRITE);
        inRead      = (state == READ);
        accept      = inWrite & iValid;
        wrLast      = (wrCnt == LAST_ADDR);
        rdLast      = (rdCnt == LAST_ADDR);
        pipeNext    = (validPipe << 1) | RD_LATENCY'(inRead);
        pipeDrained = (pipeNext == '0);
    end

    // BRAM port: write address in WRITE, read address in READ, parked at 0 otherwise.
    always_comb begin
        oRamWe    = accept;
        oRamAddr  = '0;
        oRamWData = '0;
        if (inWrite) begin
            oRamAddr  = wrCnt;
            oRamWData = iData;
        end else if (inRead) begin
            oRamAddr = rdCnt;
        end
    end

    assign oValid = validPipe[RD_LATENCY-1];
    assign oData  = oValid ? iRamRData : '0;

    // Frame sequencer with registered status outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= IDLE;
            wrCnt      <= '0;
            rdCnt      <= '0;
            validPipe  <= '0;
            oReady     <= 1'b0;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b0;
        end else begin
            oFrameDone <= 1'b0;
            validPipe  <= pipeNext;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state  <= WRITE;
                        wrCnt  <= '0;
                        rdCnt  <= '0;
                        oReady <= 1'b1;
                        oBusy  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (wrLast) begin
                            wrCnt  <= '0;
                            state  <= READ;
                            oReady <= 1'b0;
                        end else begin
                            wrCnt <= wrCnt + 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rdLast) begin
                        rdCnt <= '0;
                        state <= DRAIN;
                    end else begin
                        rdCnt <= rdCnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Leave once the last in-flight read has been presented.
                    if (pipeDrained) begin
                        state      <= IDLE;
                        oBusy      <= 1'b0;
                        oFrameDone <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Randomized bench for frame_buffer_ctrl: two instances (512/lat2 and 5/lat1), each
// compared cycle by cycle against a waveform derived from the frame schedule.
module tb_frame_buffer_ctrl;

    localparam int unsigned DEPTH_A = 512;
    localparam int unsigned LAT_A   = 2;
    localparam int unsigned AW_A    = 9;
    localparam int unsigned DEPTH_B = 5;
    localparam int unsigned LAT_B   = 1;
    localparam int unsigned AW_B    = 3;
    localparam int          MAXC    = 4096;
    localparam int          PRE     = 2;
    localparam int          TAIL    = 4;

    typedef struct {
        int we;
        int addr;
        int wdata;
        int valid;
        int odata;
        int ready;
        int busy;
        int done;
    } obs_t;

    logic       iClk = 1'b0;
    logic       rst   [2];
    logic       start [2];
    logic       vin   [2];
    logic [7:0] din   [2];

    logic            readyA, weA, validA, busyA, doneA;
    logic [AW_A-1:0] addrA;
    logic [7:0]      wdataA, rdataA, odataA;
    logic            readyB, weB, validB, busyB, doneB;
    logic [AW_B-1:0] addrB;
    logic [7:0]      wdataB, rdataB, odataB;

    int checkCnt = 0;
    int errCnt   = 0;
    int curInst  = 0;
    int curCycle = 0;

    always #5 iClk = ~iClk;

    frame_buffer_ctrl #(.RAM_DEPTH(DEPTH_A), .RAM_WIDTH(8), .ADDR_WIDTH(AW_A), .RD_LATENCY(LAT_A)) dutA (
        .iClk(iClk), .iRst(rst[0]), .iStart(start[0]), .iValid(vin[0]), .iData(din[0]),
        .oReady(readyA), .oRamWe(weA), .oRamAddr(addrA), .oRamWData(wdataA), .iRamRData(rdataA),
        .oValid(validA), .oData(odataA), .oBusy(busyA), .oFrameDone(doneA)
    );

    frame_buffer_ctrl #(.RAM_DEPTH(DEPTH_B), .RAM_WIDTH(8), .ADDR_WIDTH(AW_B), .RD_LATENCY(LAT_B)) dutB (
        .iClk(iClk), .iRst(rst[1]), .iStart(start[1]), .iValid(vin[1]), .iData(din[1]),
        .oReady(readyB), .oRamWe(weB), .oRamAddr(addrB), .oRamWData(wdataB), .iRamRData(rdataB),
        .oValid(validB), .oData(odataB), .oBusy(busyB), .oFrameDone(doneB)
    );

    // Behavioural BRAMs with fixed read latency.
    logic [7:0] memA  [DEPTH_A];
    logic [7:0] pipeA [LAT_A];
    logic [7:0] memB  [DEPTH_B];
    logic [7:0] pipeB [LAT_B];

    always @(posedge iClk) begin
        if (weA) memA[addrA] <= wdataA;
        pipeA[0] <= memA[addrA];
        for (int i = 1; i < int'(LAT_A); i++) pipeA[i] <= pipeA[i-1];
    end
    assign rdataA = pipeA[LAT_A-1];

    always @(posedge iClk) begin
        if (32'(addrB) < DEPTH_B) begin
            if (weB) memB[addrB] <= wdataB;
            pipeB[0] <= memB[addrB];
        end else begin
            pipeB[0] <= 8'h00;
        end
    end
    assign rdataB = pipeB[LAT_B-1];

    task automatic checkVal(input string tag, input int got, input int exp);
        checkCnt++;
        if (got != exp) begin
            errCnt++;
            $display("FAIL %s (inst %0d cycle %0d): got %0d, expected %0d", tag, curInst, curCycle, got, exp);
        end
    endtask

    task automatic sampleOut(input int inst, output obs_t o);
        if (inst == 0) begin
            o.we = 32'(weA); o.addr = 32'(addrA); o.wdata = 32'(wdataA); o.valid = 32'(validA);
            o.odata = 32'(odataA); o.ready = 32'(readyA); o.busy = 32'(busyA); o.done = 32'(doneA);
        end else begin
            o.we = 32'(weB); o.addr = 32'(addrB); o.wdata = 32'(wdataB); o.valid = 32'(validB);
            o.odata = 32'(odataB); o.ready = 32'(readyB); o.busy = 32'(busyB); o.done = 32'(doneB);
        end
    endtask

    task automatic driveIn(input int inst, input bit s, input bit v, input logic [7:0] d);
        start[inst] = s;
        vin[inst]   = v;
        din[inst]   = d;
    endtask

    task automatic checkAllZero(input int inst);
        obs_t o;
        sampleOut(inst, o);
        checkVal("rst_we", o.we, 0);
        checkVal("rst_addr", o.addr, 0);
        checkVal("rst_wdata", o.wdata, 0);
        checkVal("rst_valid", o.valid, 0);
        checkVal("rst_odata", o.odata, 0);
        checkVal("rst_ready", o.ready, 0);
        checkVal("rst_busy", o.busy, 0);
        checkVal("rst_done", o.done, 0);
    endtask

    // One frame: build the input schedule, derive the expected waveform from it, compare each cycle.
    // mode 0: back-to-back data=i[7:0]; 1: alternating valid; 2: random gaps and data.
    // abortRd >= 0 pulses reset asynchronously in the cycle that read address abortRd is issued.
    task automatic run_frame(input int inst, input int mode, input bit noise, input int abortRd);
        bit         sArr [MAXC];
        bit         vArr [MAXC];
        logic [7:0] dArr [MAXC];
        logic [7:0] pix  [DEPTH_A];
        int d, lat, k, g, cw, n, wcnt, abortK;
        bit wr, rd, ov;
        obs_t o, e;

        d   = (inst == 0) ? int'(DEPTH_A) : int'(DEPTH_B);
        lat = (inst == 0) ? int'(LAT_A)   : int'(LAT_B);
        curInst = inst;

        for (k = 0; k < PRE; k++) begin
            sArr[k] = 1'b0; vArr[k] = noise; dArr[k] = 8'($urandom);
        end
        sArr[PRE] = 1'b1; vArr[PRE] = 1'($urandom_range(0, 1)); dArr[PRE] = 8'($urandom);
        k = PRE + 1;
        for (int j = 0; j < d; j++) begin
            if (mode == 0)      g = 0;
            else if (mode == 1) g = (j == 0) ? 0 : 1;
            else                g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int q = 0; q < g; q++) begin
                sArr[k] = noise && ($urandom_range(0, 7) == 0);
                vArr[k] = 1'b0; dArr[k] = 8'($urandom); k++;
            end
            pix[j]  = (mode == 0) ? 8'(j) : 8'($urandom);
            sArr[k] = noise && ($urandom_range(0, 7) == 0);
            vArr[k] = 1'b1; dArr[k] = pix[j]; k++;
        end
        cw = k - 1;
        n  = cw + d + lat + 1 + TAIL;
        for (; k < n; k++) begin
            sArr[k] = noise && (k <= cw + d + lat) && ($urandom_range(0, 7) == 0);
            vArr[k] = noise; dArr[k] = 8'($urandom);
        end
        abortK = (abortRd >= 0) ? cw + 1 + abortRd : -1;

        wcnt = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge iClk); #1;
            driveIn(inst, sArr[c], vArr[c], dArr[c]);
            curCycle = c;
            if (c == abortK) begin
                #1 rst[inst] = 1'b1;
                #1 checkAllZero(inst);
                @(posedge iClk); #1;
                rst[inst] = 1'b0;
                driveIn(inst, 1'b0, 1'b0, 8'h00);
                for (int q = 0; q < lat + 4; q++) begin
                    @(negedge iClk);
                    curCycle = c + 1 + q;
                    sampleOut(inst, o);
                    checkVal("abort_done", o.done, 0);
                    checkVal("abort_busy", o.busy, 0);
                    checkVal("abort_valid", o.valid, 0);
                    checkVal("abort_addr", o.addr, 0);
                end
                return;
            end
            @(negedge iClk);
            wr = (c > PRE) && (c <= cw);
            rd = (c > cw) && (c <= cw + d);
            ov = (c > cw + lat) && (c <= cw + d + lat);
            e.ready = wr ? 1 : 0;
            e.busy  = ((c > PRE) && (c <= cw + d + lat)) ? 1 : 0;
            e.we    = (wr && vArr[c]) ? 1 : 0;
            e.addr  = wr ? wcnt : (rd ? c - cw - 1 : 0);
            e.wdata = wr ? 32'(dArr[c]) : 0;
            e.valid = ov ? 1 : 0;
            e.odata = ov ? 32'(pix[c - cw - 1 - lat]) : 0;
            e.done  = (c == cw + d + lat + 1) ? 1 : 0;
            sampleOut(inst, o);
            checkVal("ram_we", o.we, e.we);
            checkVal("ram_addr", o.addr, e.addr);
            checkVal("ram_wdata", o.wdata, e.wdata);
            checkVal("out_valid", o.valid, e.valid);
            checkVal("out_data", o.odata, e.odata);
            checkVal("ready", o.ready, e.ready);
            checkVal("busy", o.busy, e.busy);
            checkVal("frame_done", o.done, e.done);
            if (e.we == 1) wcnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; start[i] = 1'b0; vin[i] = 1'b0; din[i] = 8'h00;
        end
        #2;
        rst[0] = 1'b1; rst[1] = 1'b1;
        #1;
        curInst = 0; checkAllZero(0);
        curInst = 1; checkAllZero(1);
        @(posedge iClk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        run_frame(0, 0, 1'b0, -1);
        run_frame(0, 1, 1'b0, -1);
        run_frame(0, 0, 1'b1, -1);
        run_frame(0, 2, 1'b1, 100);
        run_frame(0, 2, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            run_frame(1, r % 3, r[0], (r == 3) ? 2 : -1);
        end
        run_frame(1, 2, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
